// File: rtl/timestamp_logger_group_collector.sv
// Timestamp logger group collector: captures per-group event messages with a free-running
// timestamp, buffers them in per-group FIFOs and drains them round-robin into one entry stream.
module timestamp_logger_group_collector #(
    parameter int NumGroups     = 3,
    parameter int MsgWidth      = 8,
    parameter int FifoDepth     = 4,
    parameter int TsWidth       = 32,
    parameter int DropCntWidth  = 8,
    parameter int GroupIdxWidth = (NumGroups > 1) ? $clog2(NumGroups) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_enable,
    input  logic                              i_change_mode,
    input  logic [NumGroups*MsgWidth-1:0]     i_msg,
    output logic                              o_entry_valid,
    input  logic                              i_entry_ready,
    output logic [GroupIdxWidth-1:0]          o_entry_group,
    output logic [MsgWidth-1:0]               o_entry_msg,
    output logic [TsWidth-1:0]                o_entry_ts,
    output logic [NumGroups*DropCntWidth-1:0] o_drop_cnt,
    input  logic                              i_clear_drop,
    output logic [TsWidth-1:0]                o_timestamp,
    output logic                              o_busy
);

    localparam int PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntWidth = PtrWidth + 1;
    localparam logic [CntWidth-1:0] FullCnt = CntWidth'(FifoDepth);

    logic [TsWidth-1:0]            r_timestamp;
    logic [NumGroups*MsgWidth-1:0] r_prev_msg;
    logic [MsgWidth-1:0]           r_fifo_msg [NumGroups][FifoDepth];
    logic [TsWidth-1:0]            r_fifo_ts  [NumGroups][FifoDepth];
    logic [PtrWidth-1:0]           r_wr_ptr   [NumGroups];
    logic [PtrWidth-1:0]           r_rd_ptr   [NumGroups];
    logic [CntWidth-1:0]           r_count    [NumGroups];
    logic [DropCntWidth-1:0]       r_drop_cnt [NumGroups];
    logic                          r_valid;
    logic [GroupIdxWidth-1:0]      r_group;
    logic [MsgWidth-1:0]           r_msg;
    logic [TsWidth-1:0]            r_ts;
    logic [GroupIdxWidth-1:0]      r_rr_ptr;

    logic [NumGroups-1:0]          w_capture;
    logic [NumGroups-1:0]          w_full;
    logic [NumGroups-1:0]          w_nonempty;
    logic [NumGroups-1:0]          w_push;
    logic [NumGroups-1:0]          w_drop;
    logic [NumGroups-1:0]          w_pop;
    logic                          w_load;
    logic                          w_grant_valid;
    logic [GroupIdxWidth-1:0]      w_grant;
    logic [GroupIdxWidth-1:0]      w_rr_next;
    logic [MsgWidth-1:0]           w_head_msg;
    logic [TsWidth-1:0]            w_head_ts;

    // Full is judged on the occupancy at the start of the cycle, so a same-cycle pop
    // never makes room for an event arriving into a full FIFO.
    always_comb begin
        w_capture  = '0;
        w_full     = '0;
        w_nonempty = '0;
        w_push     = '0;
        w_drop     = '0;
        for (int g = 0; g < NumGroups; g++) begin
            w_capture[g]  = i_enable && (i_change_mode
                ? (i_msg[g*MsgWidth +: MsgWidth] != r_prev_msg[g*MsgWidth +: MsgWidth])
                : (i_msg[g*MsgWidth +: MsgWidth] != '0));
            w_full[g]     = (r_count[g] == FullCnt);
            w_nonempty[g] = (r_count[g] != '0);
            w_push[g]     = w_capture[g] && !w_full[g];
            w_drop[g]     = w_capture[g] && w_full[g];
        end
    end

    // Handshake: an entry transfers on a cycle with o_entry_valid && i_entry_ready; while
    // valid is high and ready low, group/msg/ts hold. The output register reloads whenever
    // it is empty or its entry is being accepted.
    assign w_load = !r_valid || i_entry_ready;

    // Two-pass scan: first from the RR pointer upward, then wrap to the lowest index.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        w_head_msg    = '0;
        w_head_ts     = '0;
        for (int g = 0; g < NumGroups; g++) begin
            if (!w_grant_valid && (g >= int'(r_rr_ptr)) && w_nonempty[g]) begin
                w_grant_valid = 1'b1;
                w_grant       = GroupIdxWidth'(g);
                w_head_msg    = r_fifo_msg[g][r_rd_ptr[g]];
                w_head_ts     = r_fifo_ts[g][r_rd_ptr[g]];
            end
        end
        for (int g = 0; g < NumGroups; g++) begin
            if (!w_grant_valid && w_nonempty[g]) begin
                w_grant_valid = 1'b1;
                w_grant       = GroupIdxWidth'(g);
                w_head_msg    = r_fifo_msg[g][r_rd_ptr[g]];
                w_head_ts     = r_fifo_ts[g][r_rd_ptr[g]];
            end
        end
        w_pop = '0;
        for (int g = 0; g < NumGroups; g++) begin
            w_pop[g] = w_load && w_grant_valid && (w_grant == GroupIdxWidth'(g));
        end
        w_rr_next = (w_grant == GroupIdxWidth'(NumGroups - 1)) ? '0
                                                               : w_grant + GroupIdxWidth'(1);
    end

    always_ff @(posedge i_clk) begin
        for (int g = 0; g < NumGroups; g++) begin
            if (w_push[g]) begin
                r_fifo_msg[g][r_wr_ptr[g]] <= i_msg[g*MsgWidth +: MsgWidth];
                r_fifo_ts[g][r_wr_ptr[g]]  <= r_timestamp;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_timestamp <= '0;
            r_prev_msg  <= '0;
            r_valid     <= 1'b0;
            r_group     <= '0;
            r_msg       <= '0;
            r_ts        <= '0;
            r_rr_ptr    <= '0;
            for (int g = 0; g < NumGroups; g++) begin
                r_wr_ptr[g]   <= '0;
                r_rd_ptr[g]   <= '0;
                r_count[g]    <= '0;
                r_drop_cnt[g] <= '0;
            end
        end else begin
            if (i_enable) begin
                r_timestamp <= r_timestamp + TsWidth'(1);
            end
            r_prev_msg <= i_msg;
            for (int g = 0; g < NumGroups; g++) begin
                if (w_push[g]) begin
                    r_wr_ptr[g] <= r_wr_ptr[g] + PtrWidth'(1);
                end
                if (w_pop[g]) begin
                    r_rd_ptr[g] <= r_rd_ptr[g] + PtrWidth'(1);
                end
                case ({w_push[g], w_pop[g]})
                    2'b10:   r_count[g] <= r_count[g] + CntWidth'(1);
                    2'b01:   r_count[g] <= r_count[g] - CntWidth'(1);
                    default: r_count[g] <= r_count[g];
                endcase
                if (i_clear_drop) begin
                    r_drop_cnt[g] <= '0;
                end else if (w_drop[g] && (r_drop_cnt[g] != '1)) begin
                    r_drop_cnt[g] <= r_drop_cnt[g] + DropCntWidth'(1);
                end
            end
            if (w_load) begin
                if (w_grant_valid) begin
                    r_valid  <= 1'b1;
                    r_group  <= w_grant;
                    r_msg    <= w_head_msg;
                    r_ts     <= w_head_ts;
                    r_rr_ptr <= w_rr_next;
                end else begin
                    r_valid  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        o_drop_cnt = '0;
        for (int g = 0; g < NumGroups; g++) begin
            o_drop_cnt[g*DropCntWidth +: DropCntWidth] = r_drop_cnt[g];
        end
    end

    assign o_entry_valid = r_valid;
    assign o_entry_group = r_group;
    assign o_entry_msg   = r_msg;
    assign o_entry_ts    = r_ts;
    assign o_timestamp   = r_timestamp;
    assign o_busy        = (|w_nonempty) || r_valid;

endmodule

// File: tb/tb_timestamp_logger_group_collector.sv
// Directed bench for timestamp_logger_group_collector: stimulus pushes expected entries,
// a negedge monitor pops and compares every accepted output entry.
module tb_timestamp_logger_group_collector;
  localparam int NG = 3;
  localparam int MW = 8;
  localparam int TW = 32;
  localparam int DW = 2;
  localparam int GW = 2;
  localparam int EW = GW + MW + TW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_rst = 1'b1;
  logic            i_enable = 1'b0;
  logic            i_change_mode = 1'b0;
  logic [NG*MW-1:0] i_msg = '0;
  logic            i_entry_ready = 1'b0;
  logic            i_clear_drop = 1'b0;
  logic            o_entry_valid;
  logic [GW-1:0]   o_entry_group;
  logic [MW-1:0]   o_entry_msg;
  logic [TW-1:0]   o_entry_ts;
  logic [NG*DW-1:0] o_drop_cnt;
  logic [TW-1:0]   o_timestamp;
  logic            o_busy;

  timestamp_logger_group_collector #(
    .NumGroups(NG), .MsgWidth(MW), .FifoDepth(4), .TsWidth(TW), .DropCntWidth(DW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_change_mode(i_change_mode),
    .i_msg(i_msg), .o_entry_valid(o_entry_valid), .i_entry_ready(i_entry_ready),
    .o_entry_group(o_entry_group), .o_entry_msg(o_entry_msg), .o_entry_ts(o_entry_ts),
    .o_drop_cnt(o_drop_cnt), .i_clear_drop(i_clear_drop), .o_timestamp(o_timestamp),
    .o_busy(o_busy)
  );

  int n_vec = 0;
  int n_bad = 0;
  int model_ts = 0;
  logic [EW-1:0] exp_q[$];
  logic prev_stall = 1'b0;
  logic [EW-1:0] prev_entry = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [NG*MW-1:0] gm(input int g, input logic [MW-1:0] v);
    logic [NG*MW-1:0] r;
    r = '0;
    r[g*MW +: MW] = v;
    return r;
  endfunction

  task automatic exp_push(input logic [GW-1:0] g, input logic [MW-1:0] m, input int ts);
    exp_q.push_back({g, m, TW'(ts)});
  endtask

  task automatic step(input logic [NG*MW-1:0] msg);
    i_msg = msg;
    @(posedge clk);
    if (i_enable && !i_rst) model_ts++;
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_msg = '0;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    model_ts = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 64; i++) begin
      if (!o_busy && exp_q.size() == 0) break;
      step('0);
    end
    check("drain_busy", 64'(o_busy), 64'(0));
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  // Scoreboard monitor: compares every accepted entry, and holds outputs steady under stall.
  always @(negedge clk) begin
    if (!i_rst) begin
      if (prev_stall && o_entry_valid) begin
        n_vec++;
        if ({o_entry_group, o_entry_msg, o_entry_ts} !== prev_entry) begin
          n_bad++;
          $display("FAIL stall_stable got %0h expected %0h",
                   {o_entry_group, o_entry_msg, o_entry_ts}, prev_entry);
        end
      end
      if (o_entry_valid && i_entry_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_entry got grp=%0d msg=%0h ts=%0d expected none",
                   o_entry_group, o_entry_msg, o_entry_ts);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          if ({o_entry_group, o_entry_msg, o_entry_ts} !== e) begin
            n_bad++;
            $display("FAIL entry got grp=%0d msg=%0h ts=%0d expected grp=%0d msg=%0h ts=%0d",
                     o_entry_group, o_entry_msg, o_entry_ts,
                     e[EW-1 -: GW], e[TW +: MW], e[TW-1:0]);
          end
        end
      end
      prev_stall = o_entry_valid && !i_entry_ready;
      prev_entry = {o_entry_group, o_entry_msg, o_entry_ts};
    end else begin
      prev_stall = 1'b0;
    end
  end

  int t0;

  initial begin
    // Reset values
    do_reset();
    check("rst_valid", 64'(o_entry_valid), 64'(0));
    check("rst_timestamp", 64'(o_timestamp), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_drop", 64'(o_drop_cnt), 64'(0));
    check("rst_entry_ts", 64'(o_entry_ts), 64'(0));
    check("rst_entry_msg", 64'(o_entry_msg), 64'(0));

    // Single event at ts=10, latency t+2
    i_enable = 1'b1;
    i_change_mode = 1'b0;
    i_entry_ready = 1'b1;
    while (model_ts != 10) step('0);
    check("ts_at_10", 64'(o_timestamp), 64'(10));
    exp_push(2'd1, 8'h05, 10);
    step(gm(1, 8'h05));
    check("lat_t1_valid", 64'(o_entry_valid), 64'(0));
    step('0);
    check("lat_t2_valid", 64'(o_entry_valid), 64'(1));
    check("lat_t2_busy", 64'(o_busy), 64'(1));
    wait_drain();

    // Round robin from pointer 0, then from pointer 2
    do_reset();
    step('0);
    t0 = model_ts;
    exp_push(2'd0, 8'h11, t0);
    exp_push(2'd1, 8'h22, t0);
    exp_push(2'd2, 8'h33, t0);
    step(gm(0, 8'h11) | gm(1, 8'h22) | gm(2, 8'h33));
    wait_drain();
    exp_push(2'd1, 8'h44, model_ts);
    step(gm(1, 8'h44));
    wait_drain();
    t0 = model_ts;
    exp_push(2'd2, 8'h77, t0);
    exp_push(2'd0, 8'h55, t0);
    exp_push(2'd1, 8'h66, t0);
    step(gm(0, 8'h55) | gm(1, 8'h66) | gm(2, 8'h77));
    wait_drain();

    // Backpressure / overflow: 4 in FIFO + 1 in output register, 2 dropped
    do_reset();
    i_entry_ready = 1'b0;
    t0 = model_ts;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) exp_push(2'd0, MW'(i + 1), model_ts);
      step(gm(0, MW'(i + 1)));
    end
    step('0);
    step('0);
    check("ovf_valid", 64'(o_entry_valid), 64'(1));
    check("ovf_head_msg", 64'(o_entry_msg), 64'(1));
    check("ovf_head_ts", 64'(o_entry_ts), 64'(t0));
    check("ovf_head_group", 64'(o_entry_group), 64'(0));
    check("ovf_drop0", 64'(o_drop_cnt[0 +: DW]), 64'(2));
    check("ovf_drop1", 64'(o_drop_cnt[DW +: DW]), 64'(0));
    check("ovf_busy", 64'(o_busy), 64'(1));
    i_entry_ready = 1'b1;
    wait_drain();

    // Change mode: group2 sequence 0,3,3,7,0 -> entries 3,7,0
    i_change_mode = 1'b1;
    step('0);
    exp_push(2'd2, 8'h03, model_ts);
    step(gm(2, 8'h03));
    step(gm(2, 8'h03));
    exp_push(2'd2, 8'h07, model_ts);
    step(gm(2, 8'h07));
    exp_push(2'd2, 8'h00, model_ts);
    step('0);
    step('0);
    wait_drain();
    i_change_mode = 1'b0;

    // Drop saturation and clear priority
    do_reset();
    i_entry_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 5) exp_push(2'd0, MW'(8'h11 + i), model_ts);
      step(gm(0, MW'(8'h11 + i)));
    end
    check("sat_drop0", 64'(o_drop_cnt[0 +: DW]), 64'(3));
    i_clear_drop = 1'b1;
    step(gm(0, 8'h1B));
    i_clear_drop = 1'b0;
    check("clear_vs_drop", 64'(o_drop_cnt[0 +: DW]), 64'(0));
    step(gm(0, 8'h1C));
    check("drop_after_clear", 64'(o_drop_cnt[0 +: DW]), 64'(1));
    i_entry_ready = 1'b1;
    wait_drain();

    // Enable low: timestamp frozen, messages ignored, buffered entries drain
    do_reset();
    i_entry_ready = 1'b0;
    exp_push(2'd0, 8'h21, model_ts);
    step(gm(0, 8'h21));
    exp_push(2'd0, 8'h22, model_ts);
    step(gm(0, 8'h22));
    i_enable = 1'b0;
    t0 = model_ts;
    for (int i = 0; i < 3; i++) step(gm(0, 8'h23));
    check("ts_frozen", 64'(o_timestamp), 64'(t0));
    i_entry_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(gm(1, 8'h24));
    wait_drain();
    check("ts_frozen_after_drain", 64'(o_timestamp), 64'(t0));

    // Reset with two entries pending
    i_enable = 1'b1;
    i_entry_ready = 1'b0;
    step(gm(0, 8'h31));
    step(gm(0, 8'h32));
    step('0);
    step('0);
    check("pend_valid", 64'(o_entry_valid), 64'(1));
    check("pend_busy", 64'(o_busy), 64'(1));
    i_rst = 1'b1;
    step('0);
    i_rst = 1'b0;
    model_ts = 0;
    check("midrst_valid", 64'(o_entry_valid), 64'(0));
    check("midrst_busy", 64'(o_busy), 64'(0));
    check("midrst_timestamp", 64'(o_timestamp), 64'(0));
    i_entry_ready = 1'b1;
    for (int i = 0; i < 5; i++) step('0);
    check("midrst_no_stale", 64'(o_entry_valid), 64'(0));
    check("ts_after_rst", 64'(o_timestamp), 64'(model_ts));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
